// File: rtl/crossbar_sw_alloc.sv
// crossbar_sw_alloc: wormhole switch allocator for a P-port router.
// One round-robin arbiter per output, with a packet lock held from head flit
// to tail flit. Grants are combinational from the current state and inputs.
// Optional lock watchdog: define SW_ALLOC_LOCK_TIMEOUT_EN to force-release an
// output lock after LOCK_TIMEOUT-1 consecutive cycles without a grant.
module crossbar_sw_alloc #(
  parameter int P            = 5,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P-1:0]         req_valid_all,
  input  logic [P-1:0]         req_head_all,
  input  logic [P-1:0]         req_tail_all,
  input  logic [P*(P-1)-1:0]   req_dest_all,
  input  logic [P-1:0]         out_ready_all,
  output logic [P*(P-1)-1:0]   granted_dest_port_all,
  output logic [P-1:0]         in_grant_all,
  output logic [P-1:0]         out_busy_all,
  output logic [P-1:0]         lock_timeout_all
);

  localparam int IW = (P > 1) ? $clog2(P) : 1;

  logic [P-1:0][P-2:0] dest_s;
  logic [P-1:0][P-1:0] req_mat;   // req_mat[o][i]: input i validly targets output o
  logic [P-1:0][P-1:0] gnt;       // gnt[o][i]: output o grants input i
  logic [P-1:0][IW-1:0] win;
  logic [P-1:0]        any_gnt;
  logic [P-1:0]        win_tail;
  logic [P-1:0]        tmo_fire;
  logic [P-1:0][P-2:0] gd;

  logic [P-1:0]         locked_q;
  logic [P-1:0][IW-1:0] owner_q;
  logic [P-1:0][IW-1:0] prio_q;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (x == IW'(P-1)) ? '0 : x + 1'b1;
  endfunction

  assign dest_s = req_dest_all;

  // Decode each input's destination; non-one-hot slices are dropped.
  always_comb begin
    req_mat = '0;
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++) begin
        if (i != o) begin
          if (o < i) req_mat[o][i] = req_valid_all[i] && $onehot(dest_s[i]) && dest_s[i][o];
          else       req_mat[o][i] = req_valid_all[i] && $onehot(dest_s[i]) && dest_s[i][o-1];
        end
      end
    end
  end

  // Per-output arbitration: round-robin over heads when idle, owner-only when locked.
  always_comb begin
    gnt      = '0;
    win      = '0;
    any_gnt  = '0;
    win_tail = '0;
    for (int o = 0; o < P; o++) begin
      logic found;
      found = 1'b0;
      if (locked_q[o]) begin
        for (int i = 0; i < P; i++) begin
          if (IW'(i) == owner_q[o] && req_mat[o][i]) begin
            found  = 1'b1;
            win[o] = IW'(i);
          end
        end
      end else begin
        // first pass: inputs at or above the priority pointer; second pass wraps
        for (int i = 0; i < P; i++) begin
          if (!found && req_mat[o][i] && req_head_all[i] && IW'(i) >= prio_q[o]) begin
            found  = 1'b1;
            win[o] = IW'(i);
          end
        end
        for (int i = 0; i < P; i++) begin
          if (!found && req_mat[o][i] && req_head_all[i]) begin
            found  = 1'b1;
            win[o] = IW'(i);
          end
        end
      end
      if (found && out_ready_all[o]) begin
        for (int i = 0; i < P; i++) begin
          if (IW'(i) == win[o]) begin
            gnt[o][i]   = 1'b1;
            win_tail[o] = req_tail_all[i];
          end
        end
        any_gnt[o] = 1'b1;
      end
    end
  end

  // Fold per-output grants back into per-input views; all quiet during reset.
  always_comb begin
    in_grant_all = '0;
    gd           = '0;
    for (int i = 0; i < P; i++) begin
      for (int o = 0; o < P; o++) begin
        in_grant_all[i] = in_grant_all[i] | (gnt[o][i] & reset);
      end
      for (int k = 0; k < P-1; k++) begin
        if (k < i) gd[i][k] = gnt[k][i] & reset;
        else       gd[i][k] = gnt[k+1][i] & reset;
      end
    end
  end

  assign granted_dest_port_all = gd;
  assign out_busy_all          = locked_q;

  // Lock / owner / priority state per output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_q <= '0;
      owner_q  <= '0;
      prio_q   <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        if (any_gnt[o]) begin
          if (locked_q[o]) begin
            if (win_tail[o]) begin
              locked_q[o] <= 1'b0;
              prio_q[o]   <= next_idx(owner_q[o]);
            end
          end else if (win_tail[o]) begin
            prio_q[o] <= next_idx(win[o]);
          end else begin
            locked_q[o] <= 1'b1;
            owner_q[o]  <= win[o];
          end
        end else if (tmo_fire[o]) begin
          locked_q[o] <= 1'b0;
          prio_q[o]   <= next_idx(owner_q[o]);
        end
      end
    end
  end

`ifdef SW_ALLOC_LOCK_TIMEOUT_EN
  localparam int CW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  logic [P-1:0][CW-1:0] cnt_q;
  logic [P-1:0]         tmo_q;

  // The idle cycle that brings the count to LOCK_TIMEOUT-1 releases the lock.
  always_comb begin
    tmo_fire = '0;
    for (int o = 0; o < P; o++) begin
      tmo_fire[o] = locked_q[o] && !any_gnt[o] && (cnt_q[o] == CW'(LOCK_TIMEOUT-2));
    end
  end

  // Idle-cycle counters and the registered one-cycle release pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        tmo_q[o] <= tmo_fire[o];
        if (!locked_q[o] || any_gnt[o] || tmo_fire[o]) cnt_q[o] <= '0;
        else                                          cnt_q[o] <= cnt_q[o] + 1'b1;
      end
    end
  end

  assign lock_timeout_all = tmo_q;
`else
  assign tmo_fire         = '0;
  assign lock_timeout_all = '0;
`endif

endmodule

// File: tb/tb_crossbar_sw_alloc.sv
// Self-checking bench for crossbar_sw_alloc (P=5, LOCK_TIMEOUT=8).
module tb_crossbar_sw_alloc;

  localparam int P  = 5;
  localparam int LT = 8;
  localparam int NS = P*(P-1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [P-1:0]  v, h, t, r;
  logic [NS-1:0] d;
  logic [NS-1:0] granted_dest_port_all;
  logic [P-1:0]  in_grant_all, out_busy_all, lock_timeout_all;

  int total = 0;
  int bad   = 0;

  crossbar_sw_alloc #(.P(P), .LOCK_TIMEOUT(LT)) dut (
    .clk                   (clk),
    .reset                 (reset_n),
    .req_valid_all         (v),
    .req_head_all          (h),
    .req_tail_all          (t),
    .req_dest_all          (d),
    .out_ready_all         (r),
    .granted_dest_port_all (granted_dest_port_all),
    .in_grant_all          (in_grant_all),
    .out_busy_all          (out_busy_all),
    .lock_timeout_all      (lock_timeout_all)
  );

  always #5 clk = ~clk;

  // slice placement for "input i goes to output o"
  function automatic logic [NS-1:0] dv(input int i, input int o);
    logic [NS-1:0] x;
    x = '0;
    x[i*(P-1) + ((o < i) ? o : o-1)] = 1'b1;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_busy[P], m_owner[P], m_prio[P], m_cnt[P], m_pulse[P], e_win[P];
  logic [P-1:0]  e_gnt, e_busy, e_tmo;
  logic [NS-1:0] e_gd;

  task automatic model_reset();
    for (int o = 0; o < P; o++) begin
      m_busy[o] = 0; m_owner[o] = 0; m_prio[o] = 0; m_cnt[o] = 0; m_pulse[o] = 0;
    end
  endtask

  task automatic model_eval();
    int dst[P];
    logic [P-2:0] s;
    for (int i = 0; i < P; i++) begin
      dst[i] = -1;
      s = d[i*(P-1) +: (P-1)];
      if (v[i] && $countones(s) == 1)
        for (int k = 0; k < P-1; k++) if (s[k]) dst[i] = (k < i) ? k : k+1;
    end
    e_gnt = '0; e_gd = '0; e_busy = '0; e_tmo = '0;
    for (int o = 0; o < P; o++) begin
      e_win[o] = -1;
      if (r[o]) begin
        if (m_busy[o] != 0) begin
          if (dst[m_owner[o]] == o) e_win[o] = m_owner[o];
        end else begin
          for (int j = 0; j < P; j++) begin
            int c;
            c = (m_prio[o] + j) % P;
            if (e_win[o] < 0 && dst[c] == o && h[c]) e_win[o] = c;
          end
        end
      end
      if (e_win[o] >= 0) begin
        e_gnt[e_win[o]] = 1'b1;
        e_gd = e_gd | dv(e_win[o], o);
      end
      e_busy[o] = (m_busy[o] != 0);
      e_tmo[o]  = (m_pulse[o] != 0);
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < P; o++) begin
      int w;
      w = e_win[o];
      m_pulse[o] = 0;
      if (w >= 0) begin
        m_cnt[o] = 0;
        if (m_busy[o] != 0) begin
          if (t[w]) begin m_busy[o] = 0; m_prio[o] = (m_owner[o] + 1) % P; end
        end else if (t[w]) begin
          m_prio[o] = (w + 1) % P;
        end else begin
          m_busy[o] = 1; m_owner[o] = w;
        end
      end else begin
`ifdef SW_ALLOC_LOCK_TIMEOUT_EN
        if (m_busy[o] != 0) begin
          if (m_cnt[o] == LT-2) begin
            m_busy[o] = 0; m_prio[o] = (m_owner[o] + 1) % P; m_cnt[o] = 0; m_pulse[o] = 1;
          end else m_cnt[o]++;
        end else m_cnt[o] = 0;
`endif
      end
    end
  endtask

  // one model-checked cycle: inputs already driven at posedge+1
  task automatic mstep(input string nm);
    @(negedge clk);
    model_eval();
    chk({nm, ".in_grant"}, 32'(in_grant_all), 32'(e_gnt));
    chk({nm, ".granted"},  32'(granted_dest_port_all), 32'(e_gd));
    chk({nm, ".busy"},     32'(out_busy_all), 32'(e_busy));
    chk({nm, ".timeout"},  32'(lock_timeout_all), 32'(e_tmo));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v = '1; h = '1; t = '1; r = '1;
    d = dv(0,1) | dv(1,2) | dv(2,3) | dv(3,4) | dv(4,0);
    #2;
    chk("rst.in_grant", 32'(in_grant_all), 32'd0);
    chk("rst.granted",  32'(granted_dest_port_all), 32'd0);
    chk("rst.busy",     32'(out_busy_all), 32'd0);
    chk("rst.timeout",  32'(lock_timeout_all), 32'd0);
    @(negedge clk);
    v = '0; h = '0; t = '0; d = '0;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [P-1:0]  v, h, t, r;
    logic [NS-1:0] d;
    logic [P-1:0]  eg;
    logic [NS-1:0] egd;
    logic [P-1:0]  eb;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [NS-1:0] tmp;
    int ord[12];
    int fl[3];
    logic [P-1:0] g;
    logic [P-1:0] exp_b0;

    reset_n = 1'b0; v = '0; h = '0; t = '0; r = '0; d = '0;
    #1;

    // single flit 1->3
    tbl[0]  = '{5'b00010, 5'b00010, 5'b00010, 5'b11111, dv(1,3), 5'b00010, dv(1,3), 5'b00000};
    // body flit to idle output, and an input with a two-hot slice
    tmp = dv(0,2); tmp[3*(P-1) +: (P-1)] = 4'b0101;
    tbl[1]  = '{5'b01001, 5'b01000, 5'b01000, 5'b11111, tmp, 5'b00000, '0, 5'b00000};
    // all-zero slice
    tbl[2]  = '{5'b10000, 5'b10000, 5'b10000, 5'b11111, '0, 5'b00000, '0, 5'b00000};
    // independent outputs in one cycle: 2 locks 4, 3 single flit to 1
    tbl[3]  = '{5'b01100, 5'b01100, 5'b01000, 5'b11111, dv(2,4)|dv(3,1), 5'b01100, dv(2,4)|dv(3,1), 5'b00000};
    // input 0 head to locked 4 is blocked
    tbl[4]  = '{5'b01101, 5'b01001, 5'b01000, 5'b11111, dv(2,4)|dv(0,4)|dv(3,1), 5'b01100, dv(2,4)|dv(3,1), 5'b10000};
    // output 4 not ready
    tbl[5]  = '{5'b00101, 5'b00001, 5'b00000, 5'b01111, dv(2,4)|dv(0,4), 5'b00000, '0, 5'b10000};
    // tail of 2 on 4
    tbl[6]  = '{5'b00101, 5'b00001, 5'b00100, 5'b11111, dv(2,4)|dv(0,4), 5'b00100, dv(2,4), 5'b10000};
    // output 4 free: prio now 3, 0 wins by wrap
    tbl[7]  = '{5'b00001, 5'b00001, 5'b00001, 5'b11111, dv(0,4), 5'b00001, dv(0,4), 5'b00000};
    // 1 locks output 0, then repeats a head (treated as body), then tail
    tbl[8]  = '{5'b00010, 5'b00010, 5'b00000, 5'b11111, dv(1,0), 5'b00010, dv(1,0), 5'b00000};
    tbl[9]  = '{5'b00010, 5'b00010, 5'b00000, 5'b11111, dv(1,0), 5'b00010, dv(1,0), 5'b00001};
    tbl[10] = '{5'b00010, 5'b00000, 5'b00010, 5'b11111, dv(1,0), 5'b00010, dv(1,0), 5'b00001};
    tbl[11] = '{5'b00000, 5'b00000, 5'b00000, 5'b11111, '0, 5'b00000, '0, 5'b00000};

    do_reset();
    for (int n = 0; n < 12; n++) begin
      v = tbl[n].v; h = tbl[n].h; t = tbl[n].t; r = tbl[n].r; d = tbl[n].d;
      @(negedge clk);
      chk($sformatf("tbl%0d.in_grant", n), 32'(in_grant_all), 32'(tbl[n].eg));
      chk($sformatf("tbl%0d.granted", n),  32'(granted_dest_port_all), 32'(tbl[n].egd));
      chk($sformatf("tbl%0d.busy", n),     32'(out_busy_all), 32'(tbl[n].eb));
      @(posedge clk);
      #1;
    end

    // three 3-flit packets contend continuously for output 4
    do_reset();
    ord = '{0,0,0,1,1,1,2,2,2,0,0,0};
    fl  = '{0,0,0};
    for (int c = 0; c < 12; c++) begin
      v = 5'b00111; r = '1; h = '0; t = '0;
      d = dv(0,4) | dv(1,4) | dv(2,4);
      for (int i = 0; i < 3; i++) begin
        h[i] = (fl[i] == 0);
        t[i] = (fl[i] == 2);
      end
      @(negedge clk);
      g = in_grant_all;
      chk($sformatf("rr%0d.in_grant", c), 32'(g), 32'(1 << ord[c]));
      chk($sformatf("rr%0d.busy4", c), 32'(out_busy_all[4]), 32'((c % 3) != 0));
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (g[i]) fl[i] = (fl[i] + 1) % 3;
    end

    // stall of a locked output: 2 owns 0, ready[0] low for 4 cycles, 3 waits
    do_reset();
    v = 5'b00100; h = 5'b00100; t = '0; r = '1; d = dv(2,0);
    @(negedge clk);
    chk("stall.head", 32'(in_grant_all), 32'b00100);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      v = 5'b01100; h = 5'b01000; t = 5'b01000; r = 5'b11110; d = dv(2,0) | dv(3,0);
      @(negedge clk);
      chk($sformatf("stall%0d.in_grant", c), 32'(in_grant_all), 32'd0);
      chk($sformatf("stall%0d.busy", c), 32'(out_busy_all), 32'b00001);
      @(posedge clk); #1;
    end
    r = '1;
    @(negedge clk);
    chk("stall.resume", 32'(in_grant_all), 32'b00100);
    @(posedge clk); #1;
    t = 5'b01100;
    @(negedge clk);
    chk("stall.tail", 32'(in_grant_all), 32'b00100);
    @(posedge clk); #1;
    v = 5'b01000;
    @(negedge clk);
    chk("stall.next", 32'(in_grant_all), 32'b01000);
    chk("stall.idle", 32'(out_busy_all), 32'd0);
    @(posedge clk); #1;

    // owner goes silent on a held lock; another head waits for output 0
    do_reset();
    v = 5'b00010; h = 5'b00010; t = '0; r = '1; d = dv(1,0);
    mstep("abandon.head");
    for (int c = 0; c < 100; c++) begin
      v = 5'b00100; h = 5'b00100; t = 5'b00100; r = '1; d = dv(2,0);
      mstep($sformatf("abandon%0d", c));
    end
`ifdef SW_ALLOC_LOCK_TIMEOUT_EN
    exp_b0 = 5'b00000;
`else
    exp_b0 = 5'b00001;
`endif
    chk("abandon.busy_after", 32'(out_busy_all), 32'(exp_b0));

    // randomized traffic against the model, with an asynchronous reset midway
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      d = '0;
      for (int i = 0; i < P; i++) begin
        int o;
        v[i] = ($urandom_range(0, 3) != 0);
        h[i] = ($urandom_range(0, 4) < 2);
        t[i] = ($urandom_range(0, 4) < 2);
        r[i] = ($urandom_range(0, 6) != 0);
        if ($urandom_range(0, 7) == 0) begin
          d[i*(P-1) +: (P-1)] = 4'($urandom_range(0, 15));
        end else begin
          o = $urandom_range(0, P-2);
          if (o >= i) o = o + 1;
          d = d | dv(i, o);
        end
      end
      mstep($sformatf("rnd%0d", c));
    end

    v = '0; h = '0; t = '0; d = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crossbar_sw_alloc.md
Name: crossbar_sw_alloc

Overview:
Wormhole switch allocator that drives the router crossbar's granted_dest_port_all bus. It runs one round-robin arbiter per output port, with a per-output packet lock from head flit to tail flit. It also issues the per-input grant that pops the winning input buffer. It sits between the input-port VC/buffer stage and the crossbar, in the same P-port router.

Parameters:
P, 5, router port count (P>=3)
LOCK_TIMEOUT, 64, idle cycles before a lock is force-released (used only with the optional feature, >=2)

Ports:
clk  input  1  router clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid_all  input  P  input port i has a flit ready at its head
req_head_all  input  P  that flit is a head flit
req_tail_all  input  P  that flit is a tail flit (head and tail both set means a single-flit packet)
req_dest_all  input  P*(P-1)  per input i: one-hot over the other P-1 outputs; bit k means output k if k<i, else output k+1
out_ready_all  input  P  output o can accept a flit this cycle (credit available)
granted_dest_port_all  output  P*(P-1)  per input i: one-hot granted output, same encoding as req_dest_all; feeds the crossbar
in_grant_all  output  P  input i's flit is transferred this cycle
out_busy_all  output  P  output o is locked to a packet
lock_timeout_all  output  P  one-cycle pulse when output o's lock is force-released

Behaviour:
- Reset (reset=0, async): every output arbiter goes to IDLE, owner=0, prio=0, timeout counters=0. All outputs are driven to 0 while reset is asserted.
- Grant outputs are combinational from the current state and this cycle's inputs, with zero-cycle latency. All state updates on posedge clk.
- A request is valid only if req_valid_all[i]=1 and req_dest_all slice i is exactly one-hot. A non-one-hot slice, including all zeros, is ignored (no grant).
- Per output o, the requester set is inputs i!=o whose decoded destination is o.
- State IDLE:
  - Eligible requesters are those that are valid, destined to o, and have head=1.
  - The winner is the first eligible input scanning i=prio[o], prio[o]+1, ... modulo P.
  - A grant is issued only if out_ready_all[o]=1.
  - On grant with tail=1: stay in IDLE and set prio[o]=(winner+1) mod P.
  - On grant with tail=0: go to LOCKED with owner[o]=winner.
  - Non-head flits are never granted in IDLE.
- State LOCKED:
  - Only owner[o] may be granted, when it is valid, destined to o, and out_ready_all[o]=1. Other requesters are blocked.
  - A head flit from the owner while LOCKED is a protocol violation; it is granted as a body flit.
  - On a granted tail: go to IDLE and set prio[o]=(owner+1) mod P. The release applies from the next cycle, so a new head to o is first considered in the following cycle.
- On grant, set granted_dest_port_all bit (i, o) and in_grant_all[i]=1.
- Each input targets at most one output, so at most one bit is set per input slice and no input-side conflict arises.
- out_busy_all[o]=1 exactly while output o is LOCKED.
- When out_ready_all[o]=0: no grant to o, and state and prio are held.
- A mid-packet reset drops the lock immediately. Upstream is responsible for flushing partial packets.

Optional Feature:
- Macro SW_ALLOC_LOCK_TIMEOUT_EN.
- When defined: each LOCKED output has a counter that increments every cycle in which no grant is issued to that output and resets to 0 on a grant.
  - When the counter reaches LOCK_TIMEOUT-1 without a grant, the output returns to IDLE and prio=(owner+1) mod P.
  - lock_timeout_all[o] pulses for that one cycle and the counter clears.
  - Counter width is clog2(LOCK_TIMEOUT).
- When not defined: no counters exist, locks persist indefinitely, and lock_timeout_all is tied to 0.

Test Plan:
1. P=5 reset release. Input 1 sends a single-flit packet (head=tail=1) to output 3 with out_ready=1F → same cycle: in_grant_all=00010, input-1 slice=0100 (k=2), out_busy stays 0, prio[3]=2.
2. Inputs 0, 1 and 2 each send 3-flit packets to output 4 continuously → grants go to input 0 (3 flits), then 1, then 2, then 0. No interleaving. out_busy[4]=1 through each packet and 0 for one cycle between packets.
3. Input 2 is locked on output 0 and out_ready[0] deasserts for 4 cycles mid-packet → no grants in those cycles. State, owner and prio are held. Transfer resumes with input 2 on reassert.
4. Input 2 holds a lock on output 4 while input 3 requests output 1 simultaneously → both are granted in the same cycle (in_grant=01100) with independent arbiters.
5. Non-head flit from input 0 to idle output 2, and a request with dest slice=0101 → neither is granted and state is unchanged.
6. With SW_ALLOC_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8: owner 1 on output 0 stalls (valid=0) for 7 cycles → lock_timeout_all[0] pulses, out_busy[0] drops, and input 2's head is granted on the next cycle. Without the macro the lock is still held after 100 cycles.
